ac97_cmd_scheduler: RTL and testbench
=====================================

# ac97_cmd_scheduler

Shares the AC97 codec control channel (slot 1 command address, slot 2 command data) among several register-write requesters, e.g. init sequencer, volume control and record-gain control. It buffers accepted writes in a small FIFO and releases at most one per AC-link frame, after the codec power-up wait. Its outputs feed the frame serializer's slot 0 tag bits and its slot 1/2 words. It runs in the BIT_CLK domain, beside the bit/frame counter.

## Interface
- NREQ, 2, number of requesters (2..4)
- FIFO_DEPTH, 4, command FIFO entries (power of two, 2..8)
- INIT_WAIT_FRAMES, 507, frames to wait after reset release before the first command is issued
- BIT_CLK  in  1  12.288 MHz AC-link bit clock; the block's only clock
- RESET  in  1  reset, asynchronous, active-low; while low, all state is cleared
- frame_start  in  1  one-cycle pulse from the frame counter on the cycle where bitCount==255
- req_valid  in  NREQ  per-requester write request
- req_addr  in  7*NREQ  codec register index; requester i uses bits [7i+6:7i]
- req_data  in  16*NREQ  register value; requester i uses bits [16i+15:16i]
- req_ready  out  NREQ  grant; at most one bit is high per cycle
- slot1  out  20  {1'b0 (write), addr[6:0], 12'd0}
- slot2  out  20  {data[15:0], 4'd0}
- slot_valid  out  1  drives slot 0 tag bits 14 and 13 for the current frame
- init_done  out  1  high once the power-up wait has elapsed
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- busy  out  1  FIFO is non-empty or slot_valid is high

## Operation
- Reset values:
  - every output is 0;
  - the FIFO is empty;
  - the round-robin pointer is 0;
  - the wait counter is 0;
  - the state is WAIT_INIT.
- States:
  - WAIT_INIT counts frame_start pulses. When the count reaches INIT_WAIT_FRAMES, the block sets init_done and moves to RUN.
  - RUN is permanent until the next reset.
- Arbitration:
  - Round-robin arbitration applies in both states, so requests queue during WAIT_INIT.
  - Search starts at the pointer and picks the first requester with req_valid set.
  - req_ready[i] = grant[i] & ~fifo_full. It is combinational.
  - A transfer happens when req_valid[i] and req_ready[i] are both high. The entry {addr, data} is pushed that cycle.
  - After a transfer the pointer moves to (i+1) mod NREQ. With no transfer, the pointer holds.
  - A requester holds valid, addr and data stable until it sees ready.
- Issue rule, evaluated on each frame_start in RUN:
  - FIFO non-empty: pop the head, load slot1/slot2 from it, set slot_valid = 1.
  - FIFO empty: slot_valid = 0 and slot1 = slot2 = 0.
  - Without a frame_start, the issue outputs hold.
- FIFO:
  - Depth FIFO_DEPTH, with pointers one bit wider than the index.
  - full = (wr_ptr - rd_ptr) == FIFO_DEPTH; empty = (wr_ptr == rd_ptr). Pointers wrap modulo 2*FIFO_DEPTH.
  - There is no bypass: a push in the same cycle as a pop into an empty FIFO is not visible until the next frame_start.
  - Push and pop in the same cycle when full: fifo_full is sampled at the start of the cycle, so the push is refused (ready low). The count drops by one.
- Ordering: commands go out strictly in acceptance order. There is no merging or deduplication.
- Reset mid-operation (RESET low at any time) behaves as follows:
  - queued commands are discarded immediately;
  - the slot outputs clear;
  - the init wait restarts from 0 after RESET returns high.

## Timing
- Request to grant: combinational, same cycle.
- Issue latency: slot1, slot2 and slot_valid update on the BIT_CLK edge that samples frame_start high. They are therefore stable from bitCount 0 through 255 of the next frame (256 cycles).
- An accepted command waits at least one frame boundary before it is issued. The worst case is FIFO_DEPTH frames, plus the remaining init wait if the command arrived during WAIT_INIT.
- init_done rises on the edge that samples the INIT_WAIT_FRAMES-th frame_start. The first command can issue on the next frame_start.
- Throughput:
  - accept: 1 command per cycle;
  - issue: 1 command per frame (48 kHz).

## Structure
- Shared package ac97_pkg holds:
  - slot field widths: SLOT_W=20, ADDR_W=7, DATA_W=16;
  - the slot 0 tag bit indices;
  - register index constants (MASTER_VOL=7'h02, PCM_OUT_VOL=7'h18, AUX_OUT=7'h04).
- One sub-module, ac97_cmd_fifo, is natural: a parameterised synchronous FIFO with the same RESET, exposing full/empty.
- Arbiter, wait counter and issue register stay in the top-level module.

## Test plan
- Reset, then apply INIT_WAIT_FRAMES=4 and 4 frame_start pulses with no requests → init_done rises on the 4th pulse; slot_valid stays 0.
- Requester 0 writes addr 7'h18, data 16'h0808 during WAIT_INIT → it is accepted immediately. On the first frame_start after init_done: slot1=20'h18000, slot2=20'h08080, slot_valid=1 for 256 cycles, then 0.
- Both requesters hold valid continuously → grants alternate 0, 1, 0, 1; issue order matches grant order.
- Fill the FIFO (4 entries) and keep requester 1 valid → ready stays low. On a frame_start with a pending push, the count goes to 3 and the push is accepted the following cycle.
- Assert RESET low mid-frame with 3 entries queued and slot_valid=1 → all outputs 0 within the same cycle (asynchronous). After release, init_done stays 0 until the wait completes again.
- FIFO_DEPTH=4 and 10 consecutive single-entry push/issue cycles → pointers wrap and data is intact; busy deasserts after the last frame.

Source files
------------

// File: rtl/ac97_pkg.sv
// ac97_pkg: shared AC97 control-channel definitions.
//   - slot field widths (SLOT_W, ADDR_W, DATA_W, CMD_W)
//   - slot 0 tag bit indices
//   - codec register index constants
//   - scheduler state type and the queued command record
//   - helpers that format slot 1 / slot 2 words
package ac97_pkg;

  localparam int SLOT_W = 20;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;
  localparam int CMD_W  = ADDR_W + DATA_W;

  // Slot 0 tag bits: frame valid, slot 1 valid, slot 2 valid.
  localparam int TAG_FRAME_VALID = 15;
  localparam int TAG_SLOT1_VALID = 14;
  localparam int TAG_SLOT2_VALID = 13;

  localparam logic [ADDR_W-1:0] MASTER_VOL  = 7'h02;
  localparam logic [ADDR_W-1:0] AUX_OUT     = 7'h04;
  localparam logic [ADDR_W-1:0] PCM_OUT_VOL = 7'h18;

  typedef enum logic {
    WAIT_INIT = 1'b0,
    RUN       = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  // Slot 1: bit 19 = 0 selects a register write, index in [18:12].
  function automatic logic [SLOT_W-1:0] slot1_word(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr, 12'd0};
  endfunction

  // Slot 2: 16-bit register value left-justified in the 20-bit slot.
  function automatic logic [SLOT_W-1:0] slot2_word(input logic [DATA_W-1:0] data);
    return {data, 4'd0};
  endfunction

endpackage

// File: rtl/ac97_cmd_fifo.sv
// ac97_cmd_fifo: synchronous FIFO for queued codec register writes.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (clears contents)
//   push, din    write request / data; ignored when full
//   pop          read request; ignored when empty; advances past dout
//   dout         head entry (valid while empty is low)
//   full, empty  occupancy flags, derived from registered pointers only
// Pointers carry one extra wrap bit so full and empty are distinguishable;
// they wrap modulo 2*DEPTH. DEPTH must be a power of two.
module ac97_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] PTR_DEPTH = (AW+1)'(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign full    = (wr_ptr - rd_ptr) == PTR_DEPTH;
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/ac97_cmd_scheduler.sv
// ac97_cmd_scheduler: shares the AC97 slot 1/2 control channel among NREQ
// register-write requesters. Accepted writes are queued and released at most
// one per AC-link frame, once the codec power-up wait has elapsed.
// Ports:
//   BIT_CLK      AC-link bit clock
//   RESET        asynchronous active-low reset
//   frame_start  one-cycle pulse at bitCount==255
//   req_valid/req_addr/req_data   per-requester write requests (packed)
//   req_ready    per-requester grant (combinational, one-hot or zero)
//   slot1/slot2  command address / data words for the serializer
//   slot_valid   slot 0 tag bits 14 and 13 for the current frame
//   init_done    power-up wait complete
//   fifo_full    command queue holds FIFO_DEPTH entries
//   busy         queue non-empty or a command is on the link
//   state        scheduler state, for observation
// Handshake: a requester raises req_valid with stable addr/data and holds
// them until it sees req_ready; a transfer occurs on every rising BIT_CLK
// edge where req_valid[i] and req_ready[i] are both high.
module ac97_cmd_scheduler
  import ac97_pkg::*;
#(
  parameter int NREQ             = 2,
  parameter int FIFO_DEPTH       = 4,
  parameter int INIT_WAIT_FRAMES = 507
) (
  input  logic                   BIT_CLK,
  input  logic                   RESET,
  input  logic                   frame_start,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [ADDR_W*NREQ-1:0] req_addr,
  input  logic [DATA_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [SLOT_W-1:0]      slot1,
  output logic [SLOT_W-1:0]      slot2,
  output logic                   slot_valid,
  output logic                   init_done,
  output logic                   fifo_full,
  output logic                   busy,
  output sched_state_t           state
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(INIT_WAIT_FRAMES + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(INIT_WAIT_FRAMES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  sched_state_t   state_q, state_next;
  logic [CW-1:0]  wait_cnt, wait_next;
  logic [PW-1:0]  rr_ptr, rr_next;
  logic [NREQ-1:0] grant;
  cmd_t           push_cmd;
  cmd_t           head;
  logic           push;
  logic           pop;
  logic           fifo_empty;
  logic           issue;

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    int idx;
    int nxt;
    logic found;
    grant    = '0;
    rr_next  = rr_ptr;
    push_cmd = '0;
    idx      = 0;
    nxt      = 0;
    found    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found         = 1'b1;
        grant[idx]    = 1'b1;
        push_cmd.addr = req_addr[idx*ADDR_W +: ADDR_W];
        push_cmd.data = req_data[idx*DATA_W +: DATA_W];
        nxt           = idx + 1;
        if (nxt == NREQ) nxt = 0;
        rr_next       = PW'(nxt);
      end
    end
  end

  // fifo_full is registered, so a pop in the same cycle never frees a slot
  // for a push until the following cycle.
  assign req_ready = grant & {NREQ{~fifo_full}};
  assign push      = |(req_valid & req_ready);
  assign issue     = frame_start && (state_q == RUN);
  assign pop       = issue;

  ac97_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (BIT_CLK),
    .rst_n (RESET),
    .push  (push),
    .din   (push_cmd),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge BIT_CLK or negedge RESET) begin
    if (!RESET) rr_ptr <= '0;
    else if (push) rr_ptr <= rr_next;
  end

  // Power-up wait: count frame_start pulses, then run forever.
  always_comb begin
    state_next = state_q;
    wait_next  = wait_cnt;
    if (state_q == WAIT_INIT && frame_start) begin
      wait_next = wait_cnt + CNT_ONE;
      if (wait_cnt == WAIT_LAST) state_next = RUN;
    end
  end

  always_ff @(posedge BIT_CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= WAIT_INIT;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_next;
      wait_cnt <= wait_next;
    end
  end

  // Issue register: refreshed only at frame boundaries in RUN, so the slot
  // words stay stable for the whole following frame.
  always_ff @(posedge BIT_CLK or negedge RESET) begin
    if (!RESET) begin
      slot1      <= '0;
      slot2      <= '0;
      slot_valid <= 1'b0;
    end else if (issue) begin
      if (!fifo_empty) begin
        slot1      <= slot1_word(head.addr);
        slot2      <= slot2_word(head.data);
        slot_valid <= 1'b1;
      end else begin
        slot1      <= '0;
        slot2      <= '0;
        slot_valid <= 1'b0;
      end
    end
  end

  assign init_done = (state_q == RUN);
  assign busy      = ~fifo_empty | slot_valid;
  assign state     = state_q;

endmodule

// File: tb/tb_ac97_cmd_scheduler.sv
// Bench for ac97_cmd_scheduler with NREQ=2, FIFO_DEPTH=4, INIT_WAIT_FRAMES=4.
// A queue-based reference model predicts every output each cycle; directed
// phases add hand-computed literal expectations.
module tb_ac97_cmd_scheduler;
  import ac97_pkg::*;

  localparam int NREQ  = 2;
  localparam int DEPTH = 4;
  localparam int INITW = 4;

  // ---------------- clock / reset ----------------
  logic BIT_CLK = 1'b0;
  logic RESET   = 1'b0;
  logic frame_start = 1'b0;
  always #5 BIT_CLK = ~BIT_CLK;

  logic        v0 = 1'b0, v1 = 1'b0;
  logic [6:0]  a0 = '0, a1 = '0;
  logic [15:0] d0 = '0, d1 = '0;
  logic [NREQ-1:0]  req_valid;
  logic [7*NREQ-1:0]  req_addr;
  logic [16*NREQ-1:0] req_data;
  assign req_valid = {v1, v0};
  assign req_addr  = {a1, a0};
  assign req_data  = {d1, d0};

  logic [NREQ-1:0] req_ready;
  logic [19:0]     slot1, slot2;
  logic            slot_valid, init_done, fifo_full, busy;
  sched_state_t    dbg_state;

  ac97_cmd_scheduler #(
    .NREQ(NREQ), .FIFO_DEPTH(DEPTH), .INIT_WAIT_FRAMES(INITW)
  ) dut (
    .BIT_CLK(BIT_CLK), .RESET(RESET), .frame_start(frame_start),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .slot1(slot1), .slot2(slot2),
    .slot_valid(slot_valid), .init_done(init_done), .fifo_full(fifo_full),
    .busy(busy), .state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame counter (256-cycle frames) ----------------
  logic [7:0] bc = '0;
  initial forever begin
    @(posedge BIT_CLK); #1;
    if (!RESET) begin
      bc = '0;
      frame_start = 1'b0;
    end else begin
      bc = bc + 8'd1;
      frame_start = (bc == 8'd255);
    end
  end

  // ---------------- requester drivers ----------------
  logic [22:0] sq0[$];
  logic [22:0] sq1[$];
  initial begin
    logic f0, f1;
    logic [22:0] tmp;
    forever begin
      @(negedge BIT_CLK);
      f0 = v0 && req_ready[0];
      f1 = v1 && req_ready[1];
      @(posedge BIT_CLK); #1;
      if (f0) tmp = sq0.pop_front();
      if (f1) tmp = sq1.pop_front();
      if (sq0.size() > 0) begin v0 = 1'b1; {a0, d0} = sq0[0]; end else v0 = 1'b0;
      if (sq1.size() > 0) begin v1 = 1'b1; {a1, d1} = sq1[0]; end else v1 = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  logic [22:0] mq[$];
  int          m_ptr = 0;
  int          m_cnt = 0;
  bit          m_run = 1'b0;
  logic [19:0] m_s1 = '0, m_s2 = '0;
  bit          m_v = 1'b0;

  function automatic logic [1:0] exp_ready();
    logic [1:0] r;
    int i;
    r = '0;
    if (mq.size() >= DEPTH) return r;
    for (int k = 0; k < NREQ; k++) begin
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  always @(posedge BIT_CLK or negedge RESET) begin : model
    logic [1:0]  g;
    logic [22:0] cmd;
    if (!RESET) begin
      mq.delete();
      m_ptr = 0; m_cnt = 0; m_run = 1'b0;
      m_s1 = '0; m_s2 = '0; m_v = 1'b0;
    end else begin
      g = exp_ready();
      if (frame_start) begin
        if (!m_run) begin
          m_cnt++;
          if (m_cnt == INITW) m_run = 1'b1;
        end else if (mq.size() > 0) begin
          cmd  = mq.pop_front();
          m_s1 = {1'b0, cmd[22:16], 12'h000};
          m_s2 = {cmd[15:0], 4'h0};
          m_v  = 1'b1;
        end else begin
          m_s1 = '0; m_s2 = '0; m_v = 1'b0;
        end
      end
      if (g[0] && v0) begin mq.push_back({a0, d0}); m_ptr = 1; end
      if (g[1] && v1) begin mq.push_back({a1, d1}); m_ptr = 0; end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge BIT_CLK) begin
    check("req_ready",  req_ready,  exp_ready());
    check("slot1",      slot1,      m_s1);
    check("slot2",      slot2,      m_s2);
    check("slot_valid", slot_valid, m_v);
    check("init_done",  init_done,  m_run);
    check("fifo_full",  fifo_full,  mq.size() == DEPTH);
    check("busy",       busy,       (mq.size() != 0) || m_v);
  end

  // ---------------- helpers ----------------
  // Stops on the negedge where frame_start is high (before the sampling edge).
  task automatic wait_fs(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 600 && !seen; n++) begin
      @(negedge BIT_CLK);
      if (frame_start) seen = 1'b1;
    end
    check({name, "_timeout"}, seen, 1);
  endtask

  // Stops on the negedge just after the edge that sampled frame_start.
  task automatic wait_frame_edge(input string name);
    wait_fs(name);
    @(negedge BIT_CLK);
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 3000 && busy; n++) @(negedge BIT_CLK);
    check(name, busy, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ready"}, req_ready, 0);
    check({name, "_slot1"}, slot1, 0);
    check({name, "_slot2"}, slot2, 0);
    check({name, "_valid"}, slot_valid, 0);
    check({name, "_init"},  init_done, 0);
    check({name, "_full"},  fifo_full, 0);
    check({name, "_busy"},  busy, 0);
  endtask

  // ---------------- directed phases ----------------
  logic [1:0] pat [5];
  initial begin
    int hi;
    logic [6:0]  ra;
    logic [15:0] rd;

    // Reset values
    repeat (3) @(negedge BIT_CLK);
    check_all_zero("reset");
    @(posedge BIT_CLK); #2;
    RESET = 1'b1;

    // Phase A: a write during WAIT_INIT is accepted at once, issued after init
    sq0.push_back({PCM_OUT_VOL, 16'h0808});
    @(posedge BIT_CLK);
    @(negedge BIT_CLK);
    check("init_accept", req_ready, 2'b01);
    for (int f = 1; f <= INITW; f++) begin
      wait_frame_edge("init_frame");
      if (f < INITW) check("init_early", init_done, 0);
    end
    check("init_rise", init_done, 1);
    check("init_no_issue", slot_valid, 0);
    wait_frame_edge("first_issue");
    check("first_slot1", slot1, 20'h18000);
    check("first_slot2", slot2, 20'h08080);
    check("first_valid", slot_valid, 1);
    hi = 1;
    for (int n = 0; n < 600; n++) begin
      @(negedge BIT_CLK);
      if (slot_valid) hi++;
      else break;
    end
    check("valid_cycles", hi, 256);
    check("idle_after_first", busy, 0);

    // Phase B: fill the FIFO, then a pending push waits for the pop
    for (int i = 0; i < 4; i++) sq0.push_back({7'(8'h20 + i), 16'(16'h1000 + i)});
    repeat (8) @(negedge BIT_CLK);
    check("fill_full", fifo_full, 1);
    sq1.push_back({AUX_OUT, 16'hBEEF});
    wait_fs("fill_fs");
    check("full_ready_low", req_ready, 2'b00);
    check("full_at_pop", fifo_full, 1);
    @(negedge BIT_CLK);
    check("after_pop_ready", req_ready, 2'b10);
    check("after_pop_full", fifo_full, 0);
    @(negedge BIT_CLK);
    check("refill_full", fifo_full, 1);
    wait_idle("drain_b");

    // Phase D: asynchronous reset with 3 queued and a command on the link
    for (int i = 0; i < 4; i++) sq0.push_back({MASTER_VOL, 16'(16'h3000 + i)});
    repeat (8) @(negedge BIT_CLK);
    wait_frame_edge("pre_reset");
    check("pre_reset_valid", slot_valid, 1);
    check("pre_reset_full", fifo_full, 0);
    check("pre_reset_busy", busy, 1);
    repeat (100) @(negedge BIT_CLK);
    @(posedge BIT_CLK); #3;
    RESET = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (3) @(negedge BIT_CLK);
    @(posedge BIT_CLK); #2;
    RESET = 1'b1;

    // Phase E: both requesters held valid -> grants alternate from pointer 0
    for (int i = 0; i < 3; i++) begin
      sq0.push_back({7'(8'h40 + i), 16'(16'hA000 + i)});
      sq1.push_back({7'(8'h50 + i), 16'(16'hB000 + i)});
    end
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b10; pat[4] = 2'b00;
    @(posedge BIT_CLK);
    for (int k = 0; k < 5; k++) begin
      @(negedge BIT_CLK);
      check("rr_grant", req_ready, pat[k]);
    end
    for (int f = 1; f <= INITW; f++) begin
      wait_frame_edge("reinit_frame");
      if (f < INITW) check("reinit_early", init_done, 0);
    end
    check("reinit_rise", init_done, 1);
    wait_frame_edge("rr_first_issue");
    check("rr_first_slot1", slot1, 20'h40000);
    check("rr_first_slot2", slot2, 20'hA0000);
    wait_frame_edge("rr_second_issue");
    check("rr_second_slot1", slot1, 20'h50000);
    wait_idle("drain_e");

    // Phase F: ten single push/issue rounds, wrapping the FIFO pointers
    for (int r = 0; r < 10; r++) begin
      ra = 7'($urandom_range(0, 127));
      rd = 16'($urandom_range(0, 65535));
      sq0.push_back({ra, rd});
      wait_frame_edge("wrap_issue");
      check("wrap_slot1", slot1, {1'b0, ra, 12'h000});
      check("wrap_slot2", slot2, {rd, 4'h0});
      check("wrap_valid", slot_valid, 1);
    end
    wait_frame_edge("wrap_end");
    check("wrap_end_valid", slot_valid, 0);
    check("wrap_end_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
